// File: rtl/motion_code_vlc_encoder_pkg.sv
// Shared types and constants for the MPEG-2 motion_code VLC encoder.
// The residual datapath is built only when MC_VLC_RESIDUAL_EN is defined.
package mpeg_vlc_pkg;

    localparam int MC_MAX_LEN = 11;
    localparam int MC_MAX_MAG = 16;

    typedef enum logic [1:0] {
        IDLE,
        CODE,
        RES
    } mc_state_e;

    typedef struct packed {
        logic [10:0] bits;
        logic [3:0]  len;
    } mc_vlc_t;

endpackage

// File: rtl/motion_code_vlc_encoder_rom.sv
// Magnitude -> codeword lookup. Prefix is left-aligned with the sign slot left at zero;
// out-of-range magnitudes return length 0.
module motion_code_vlc_rom
    import mpeg_vlc_pkg::*;
(
    input  logic [4:0] i_mag,
    output mc_vlc_t    o_vlc
);

    always_comb begin
        o_vlc = '{bits: '0, len: '0};
        case (i_mag)
            5'd0:  o_vlc = '{bits: 11'b10000000000, len: 4'd1};
            5'd1:  o_vlc = '{bits: 11'b01000000000, len: 4'd3};
            5'd2:  o_vlc = '{bits: 11'b00100000000, len: 4'd4};
            5'd3:  o_vlc = '{bits: 11'b00010000000, len: 4'd5};
            5'd4:  o_vlc = '{bits: 11'b00001100000, len: 4'd7};
            5'd5:  o_vlc = '{bits: 11'b00001010000, len: 4'd8};
            5'd6:  o_vlc = '{bits: 11'b00001000000, len: 4'd8};
            5'd7:  o_vlc = '{bits: 11'b00000110000, len: 4'd8};
            5'd8:  o_vlc = '{bits: 11'b00000101100, len: 4'd10};
            5'd9:  o_vlc = '{bits: 11'b00000101000, len: 4'd10};
            5'd10: o_vlc = '{bits: 11'b00000100100, len: 4'd10};
            5'd11: o_vlc = '{bits: 11'b00000100010, len: 4'd11};
            5'd12: o_vlc = '{bits: 11'b00000100000, len: 4'd11};
            5'd13: o_vlc = '{bits: 11'b00000011110, len: 4'd11};
            5'd14: o_vlc = '{bits: 11'b00000011100, len: 4'd11};
            5'd15: o_vlc = '{bits: 11'b00000011010, len: 4'd11};
            5'd16: o_vlc = '{bits: 11'b00000011000, len: 4'd11};
            default: o_vlc = '{bits: '0, len: '0};
        endcase
    end

endmodule

// File: rtl/motion_code_vlc_encoder.sv
// MPEG-2 motion_code VLC serializer, one bit per cycle with valid/ready on both sides.
// Define MC_VLC_RESIDUAL_EN to append motion_residual bits after the codeword.
module motion_code_vlc_encoder
    import mpeg_vlc_pkg::*;
#(
    parameter int MAX_R_SIZE = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic signed [5:0]     in_code,
    input  logic [3:0]            in_r_size,
    input  logic [MAX_R_SIZE-1:0] in_residual,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_bit,
    output logic                  out_last,
    output logic                  err
);

`ifdef MC_VLC_RESIDUAL_EN
    localparam int SR_W = MC_MAX_LEN + MAX_R_SIZE;
`else
    localparam int SR_W = MC_MAX_LEN;
`endif
    localparam int CW = $clog2(SR_W + 1);

    mc_state_e       r_state;
    logic [SR_W-1:0] r_sr;
    logic [CW-1:0]   r_tot;
    logic            r_valid;
    logic            r_last;
    logic            r_err;

    logic                  w_neg;
    logic [5:0]            w_mag;
    logic                  w_nz;
    logic                  w_illegal;
    mc_vlc_t               w_rom;
    logic [MC_MAX_LEN-1:0] w_code;
    logic [3:0]            w_r;
    logic [SR_W-1:0]       w_load;

    assign w_neg     = in_code[5];
    assign w_mag     = w_neg ? 6'(-in_code) : $unsigned(in_code);
    assign w_nz      = (w_mag != 6'd0);
    assign w_illegal = (w_mag > 6'(MC_MAX_MAG));

    motion_code_vlc_rom u_rom (
        .i_mag (w_mag[4:0]),
        .o_vlc (w_rom)
    );

    // Sign bit lands in the last codeword slot; code 0 is never negative.
    assign w_code = w_rom.bits | (MC_MAX_LEN'(w_neg) << (4'(MC_MAX_LEN) - w_rom.len));

`ifdef MC_VLC_RESIDUAL_EN
    logic [3:0]             r_rlen;
    logic [MAX_R_SIZE-1:0]  w_res_m;
    logic [CW-1:0]          w_shamt;

    always_comb begin
        w_r = '0;
        if (w_nz) begin
            w_r = (in_r_size > 4'(MAX_R_SIZE)) ? 4'(MAX_R_SIZE) : in_r_size;
        end
    end

    // Residual is packed directly behind the codeword so one shift register serves both.
    assign w_res_m = in_residual & ~({MAX_R_SIZE{1'b1}} << w_r);
    assign w_shamt = CW'(SR_W) - CW'(w_rom.len) - CW'(w_r);
    assign w_load  = {w_code, {MAX_R_SIZE{1'b0}}} | (SR_W'(w_res_m) << w_shamt);
`else
    logic w_unused;
    assign w_unused = ^{in_r_size, in_residual};
    assign w_r      = '0;
    assign w_load   = w_code;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sr    <= '0;
            r_tot   <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_err   <= 1'b0;
`ifdef MC_VLC_RESIDUAL_EN
            r_rlen  <= '0;
`endif
        end else begin
            r_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        if (w_illegal) begin
                            r_err <= 1'b1;
                        end else begin
                            r_sr    <= w_load;
                            r_tot   <= CW'(w_rom.len) + CW'(w_r);
                            r_valid <= 1'b1;
                            r_last  <= ((CW'(w_rom.len) + CW'(w_r)) == CW'(1));
                            r_state <= CODE;
`ifdef MC_VLC_RESIDUAL_EN
                            r_rlen  <= w_r;
`endif
                        end
                    end
                end
                CODE, RES: begin
                    if (out_ready) begin
                        r_sr   <= r_sr << 1;
                        r_tot  <= r_tot - CW'(1);
                        r_last <= (r_tot == CW'(2));
                        if (r_tot == CW'(1)) begin
                            r_state <= IDLE;
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
`ifdef MC_VLC_RESIDUAL_EN
                        end else if (r_state == CODE && (r_tot - CW'(1)) == CW'(r_rlen)) begin
                            r_state <= RES;
`endif
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = r_valid;
    assign out_bit   = r_sr[SR_W-1];
    assign out_last  = r_last;
    assign err       = r_err;

endmodule

// File: tb/tb_motion_code_vlc_encoder.sv
// Randomized bench for motion_code_vlc_encoder with a bit-queue reference model.
module tb_motion_code_vlc_encoder;

    localparam int MAXR = 8;

    logic            clk = 1'b0;
    logic            rst_n, in_valid, in_ready, out_valid, out_ready, out_bit, out_last, err;
    logic [5:0]      in_code;
    logic [3:0]      in_r_size;
    logic [MAXR-1:0] in_residual;

    int checks = 0;
    int failures = 0;
    bit q[$];
    bit cap[$];
    bit exp_err = 1'b0;
    bit chk_en = 1'b0;
    bit rdy_rand = 1'b0;

    int plen[17] = '{1, 2, 3, 4, 6, 7, 7, 7, 9, 9, 9, 10, 10, 10, 10, 10, 10};
    int pval[17] = '{1, 1, 1, 1, 3, 5, 4, 3, 11, 10, 9, 17, 16, 15, 14, 13, 12};

    always #5 clk = ~clk;

    motion_code_vlc_encoder #(.MAX_R_SIZE(MAXR)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_code     (in_code),
        .in_r_size   (in_r_size),
        .in_residual (in_residual),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_bit     (out_bit),
        .out_last    (out_last),
        .err         (err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Expected bit string for one symbol, MSB first, as value v of n bits.
    task automatic model_bits(input int code, input int rs, input int res,
                              output logic [31:0] v, output int n);
        int mag;
        int r;
        mag = (code < 0) ? -code : code;
        v = '0;
        n = 0;
        for (int i = plen[mag] - 1; i >= 0; i--) begin
            v = (v << 1) | 32'((pval[mag] >> i) & 1);
            n++;
        end
        if (mag != 0) begin
            v = (v << 1) | 32'(code < 0);
            n++;
        end
`ifdef MC_VLC_RESIDUAL_EN
        r = (rs > MAXR) ? MAXR : rs;
        if (mag != 0) begin
            for (int i = r - 1; i >= 0; i--) begin
                v = (v << 1) | 32'((res >> i) & 1);
                n++;
            end
        end
`else
        r = rs + res;
`endif
    endtask

    task automatic push_model(input int code, input int rs, input int res);
        logic [31:0] v;
        int n;
        model_bits(code, rs, res, v, n);
        for (int i = n - 1; i >= 0; i--) q.push_back(v[i]);
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            q.delete();
            cap.delete();
            exp_err = 1'b0;
        end else begin
            exp_err = 1'b0;
            if (out_valid && out_ready) cap.push_back(out_bit);
            if (q.size() > 0) begin
                if (out_ready) void'(q.pop_front());
            end else if (in_valid) begin
                int c;
                c = int'($signed(in_code));
                if (c > 16 || c < -16) exp_err = 1'b1;
                else push_model(c, int'(in_r_size), int'(in_residual));
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
            chk("in_ready", 32'(in_ready), 32'(q.size() == 0));
            chk("err", 32'(err), 32'(exp_err));
            if (q.size() > 0) begin
                chk("out_bit", 32'(out_bit), 32'(q[0]));
                chk("out_last", 32'(out_last), 32'(q.size() == 1));
            end
        end
    end

    always @(posedge clk) begin
        #2;
        if (rdy_rand) out_ready = (($urandom % 4) != 0);
    end

    task automatic chk_stream(input string name, input logic [31:0] ev, input int en);
        logic [31:0] v;
        v = '0;
        foreach (cap[i]) v = (v << 1) | 32'(cap[i]);
        chk({name, "_len"}, 32'(cap.size()), 32'(en));
        chk(name, v, ev);
    endtask

    task automatic send(input int code, input int rs, input int res);
        int n;
        n = 0;
        while (!in_ready && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 400) chk("send_timeout", 32'd0, 32'd1);
        in_code = 6'(code);
        in_r_size = 4'(rs);
        in_residual = MAXR'(res);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_code = 6'($urandom);
        in_r_size = 4'($urandom);
        in_residual = MAXR'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((q.size() != 0 || !in_ready) && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 400) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        int n;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        in_code = '0;
        in_r_size = '0;
        in_residual = '0;

        model_bits(-16, 0, 0, v, n);
        chk("pin_m16", v, 32'b00000011001);
        chk("pin_m16_len", 32'(n), 32'd11);
        model_bits(1, 0, 0, v, n);
        chk("pin_p1", v, 32'b010);
        model_bits(-1, 0, 0, v, n);
        chk("pin_m1", v, 32'b011);
        model_bits(0, 3, 7, v, n);
        chk("pin_zero_len", 32'(n), 32'd1);
        model_bits(5, 3, 5, v, n);
`ifdef MC_VLC_RESIDUAL_EN
        chk("pin_p5res", v, 32'b00001010101);
        chk("pin_p5res_len", 32'(n), 32'd11);
`else
        chk("pin_p5res", v, 32'b00001010);
        chk("pin_p5res_len", 32'(n), 32'd8);
`endif

        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_bit", 32'(out_bit), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        send(0, 3, 7);
        chk("zero_last", 32'(out_last), 32'd1);
        @(posedge clk); #1;
        chk("zero_ready", 32'(in_ready), 32'd1);
        chk_stream("zero", 32'b1, 1);

        cap.delete();
        send(1, 0, 0);
        wait_idle();
        chk_stream("p1", 32'b010, 3);
        cap.delete();
        send(-1, 0, 0);
        wait_idle();
        chk_stream("m1", 32'b011, 3);

        cap.delete();
        send(-16, 0, 0);
        wait_idle();
        chk_stream("m16", 32'b00000011001, 11);

        cap.delete();
        send(5, 3, 8'h05);
        wait_idle();
`ifdef MC_VLC_RESIDUAL_EN
        chk_stream("p5res", 32'b00001010101, 11);
`else
        chk_stream("p5res", 32'b00001010, 8);
`endif

        cap.delete();
        send(9, 0, 0);
        repeat (4) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            chk("bp_hold_bit", 32'(out_bit), 32'd0);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        wait_idle();
        chk_stream("bp", 32'b0000010100, 10);

        send(20, 0, 0);
        chk("ill_err", 32'(err), 32'd1);
        chk("ill_ready", 32'(in_ready), 32'd1);
        chk("ill_valid", 32'(out_valid), 32'd0);

        send(12, 0, 0);
        repeat (5) begin
            @(posedge clk); #1;
        end
        chk("prerst_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_last", 32'(out_last), 32'd0);
        rst_n = 1'b1;
        send(3, 0, 0);
        wait_idle();
        chk_stream("after_rst", 32'b00010, 5);

        rdy_rand = 1'b1;
        for (int k = 0; k < 200; k++) begin
            int code;
            if ($urandom % 5 == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            if ($urandom % 4 == 0) code = int'($signed(6'($urandom)));
            else code = int'($urandom_range(0, 32)) - 16;
            send(code, int'($urandom_range(0, 15)), int'($urandom));
        end
        wait_idle();
        rdy_rand = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
